// File: rtl/pipelined_carry_adder_if.sv
// Valid/ready operand and result channels of the pipelined add/subtract unit.
// master drives operands and consumes results; slave is the adder itself.
interface pipelined_carry_adder_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_carry_adder.sv
// Pipelined add/subtract: one CHUNK-bit slice per stage, carry registered between stages,
// valid/ready on both ends with per-stage backpressure.
module pipelined_carry_adder #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  pipelined_carry_adder_if.slave bus
);
  localparam int unsigned CHUNK = WIDTH / STAGES;
  localparam int unsigned LAST  = STAGES - 1;

  logic [STAGES-1:0]            valid_q, valid_d;
  logic [STAGES-1:0]            adv, load;
  logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
  logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
  logic [STAGES-1:0][WIDTH-1:0] psum_q, psum_d;
  logic [STAGES-1:0]            carry_q, carry_d;
  logic                         unused_slices;

  function automatic logic [CHUNK:0] chunk_add(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic             c,
                                               input int unsigned      idx);
    return {1'b0, x[idx*CHUNK +: CHUNK]} + {1'b0, y[idx*CHUNK +: CHUNK]} + {{CHUNK{1'b0}}, c};
  endfunction

  // A stage advances when some later stage is empty, or the consumer takes the result;
  // this is the unrolled form of "successor empty or advancing".
  always_comb begin : p_flow
    logic space;
    space = bus.out_ready;
    adv   = '0;
    for (int s = int'(LAST); s >= 0; s--) begin
      adv[s] = valid_q[s] & space;
      space  = space | ~valid_q[s];
    end
  end

  assign bus.in_ready = ~valid_q[0] | adv[0];

  always_comb begin : p_load
    load    = '0;
    load[0] = bus.in_valid & bus.in_ready;
    for (int unsigned s = 1; s < STAGES; s++) begin
      load[s] = adv[s-1];
    end
    valid_d = load | (valid_q & ~adv);
  end

  always_comb begin : p_datapath
    logic [CHUNK:0] add;
    // Operands are conditioned once at capture; later stages only see a and beff.
    a_d[0]      = bus.a;
    b_d[0]      = bus.sub ? ~bus.b : bus.b;
    add         = chunk_add(a_d[0], b_d[0], bus.cin ^ bus.sub, 0);
    psum_d[0]   = '0;
    psum_d[0][CHUNK-1:0] = add[CHUNK-1:0];
    carry_d[0]  = add[CHUNK];
    for (int unsigned s = 1; s < STAGES; s++) begin
      add        = chunk_add(a_q[s-1], b_q[s-1], carry_q[s-1], s);
      a_d[s]     = a_q[s-1];
      b_d[s]     = b_q[s-1];
      psum_d[s]  = psum_q[s-1];
      psum_d[s][s*CHUNK +: CHUNK] = add[CHUNK-1:0];
      carry_d[s] = add[CHUNK];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      psum_q  <= '0;
      carry_q <= '0;
    end else begin
      valid_q <= valid_d;
      for (int unsigned s = 0; s < STAGES; s++) begin
        if (load[s]) begin
          a_q[s]     <= a_d[s];
          b_q[s]     <= b_d[s];
          psum_q[s]  <= psum_d[s];
          carry_q[s] <= carry_d[s];
        end
      end
    end
  end

  // Already-consumed operand slices ride along but are never read again.
  assign unused_slices = ^{a_q, b_q};

  assign bus.out_valid = valid_q[LAST];
  assign bus.sum       = psum_q[LAST];
  assign bus.cout      = carry_q[LAST];
  assign bus.ovf       = (a_q[LAST][WIDTH-1] == b_q[LAST][WIDTH-1]) &&
                         (psum_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);
endmodule

// File: tb/tb_pipelined_carry_adder.sv
// Directed and randomized checks of pipelined_carry_adder against an arithmetic
// reference model and an in-order scoreboard.
module tb_pipelined_carry_adder;
  localparam int unsigned W = 16;
  localparam int unsigned S = 4;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_carry_adder_if #(.WIDTH(W)) bus ();

  pipelined_carry_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int   checks = 0;
  int   failures = 0;
  int   n_in = 0;
  int   n_out = 0;
  res_t exp_q[$];
  logic hold_pend = 1'b0;
  res_t hold_val;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  // Plain integer arithmetic: a+b+cin or a-b-cin, flags from range checks.
  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub);
    res_t m;
    int ua, ub, sa, sb, full, sfull;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!sub) begin
      full  = ua + ub + int'(cin);
      sfull = sa + sb + int'(cin);
      m.cout = (full >= (1 << W));
    end else begin
      full  = ua - ub - int'(cin);
      sfull = sa - sb - int'(cin);
      m.cout = (full >= 0);
    end
    m.sum = full[W-1:0];
    m.ovf = (sfull > (1 << (W - 1)) - 1) || (sfull < -(1 << (W - 1)));
    return m;
  endfunction

  // Observe one cycle just before the edge, then advance to 1 time unit past it.
  task automatic cycle();
    res_t e;
    #2;
    if (hold_pend) begin
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_data", 32'({bus.sum, bus.cout, bus.ovf}), 32'(hold_val));
    end
    hold_pend = bus.out_valid && !bus.out_ready;
    hold_val  = {bus.sum, bus.cout, bus.ovf};
    if (bus.out_valid && bus.out_ready) begin
      n_out++;
      chk("result_expected", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sum", 32'(bus.sum), 32'(e.sum));
        chk("cout", 32'(bus.cout), 32'(e.cout));
        chk("ovf", 32'(bus.ovf), 32'(e.ovf));
      end
    end
    if (bus.in_valid && bus.in_ready) begin
      exp_q.push_back(model(bus.a, bus.b, bus.cin, bus.sub));
      n_in++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive_rand(input logic valid);
    bus.in_valid = valid;
    bus.a   = W'($urandom);
    bus.b   = W'($urandom);
    bus.cin = 1'($urandom);
    bus.sub = 1'($urandom);
  endtask

  task automatic directed(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, input logic [W-1:0] esum,
                          input logic ecout, input logic eovf);
    int lat;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.a   = a;
    bus.b   = b;
    bus.cin = cin;
    bus.sub = sub;
    cycle();
    drive_rand(1'b0);
    lat = 1;
    while (!bus.out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'(S));
    chk({tag, "_sum"}, 32'(bus.sum), 32'(esum));
    chk({tag, "_cout"}, 32'(bus.cout), 32'(ecout));
    chk({tag, "_ovf"}, 32'(bus.ovf), 32'(eovf));
    bus.out_ready = 1'b1;
    cycle();
  endtask

  task automatic drain(input string tag);
    int n;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 40) begin
      cycle();
      n++;
    end
    chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int in0, out0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    directed("basic", 16'h1234, 16'h0FFF, 1'b0, 1'b0, 16'h2233, 1'b0, 1'b0);
    directed("carry_all", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    directed("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    directed("sub_bin", 16'h0009, 16'h0003, 1'b1, 1'b1, 16'h0005, 1'b1, 1'b0);

    // Back-to-back stream: every beat accepted, one result per cycle.
    bus.out_ready = 1'b1;
    in0  = n_in;
    out0 = n_out;
    for (int i = 0; i < 64; i++) begin
      drive_rand(1'b1);
      cycle();
    end
    chk("stream_accepted", 32'(n_in - in0), 32'd64);
    drive_rand(1'b0);
    repeat (S) cycle();
    chk("stream_results", 32'(n_out - out0), 32'd64);
    chk("stream_empty", 32'(exp_q.size()), 32'd0);

    // Full stall: only S beats fit, then in_ready must drop.
    bus.out_ready = 1'b0;
    in0 = n_in;
    for (int i = 0; i < 10; i++) begin
      drive_rand(1'b1);
      cycle();
    end
    chk("stall_capacity", 32'(n_in - in0), 32'(S));
    chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
    chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
    // Random traffic with random backpressure.
    for (int i = 0; i < 120; i++) begin
      drive_rand(($urandom % 4) != 0);
      bus.out_ready = 1'(($urandom % 3) != 0);
      cycle();
    end
    drain("bp");

    // Reset with beats in flight discards them.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_rand(1'b1);
      cycle();
    end
    drive_rand(1'b0);
    chk("pre_reset_in_flight", 32'(exp_q.size()), 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    exp_q.delete();
    hold_pend = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    bus.out_ready = 1'b1;
    out0 = n_out;
    repeat (6) cycle();
    chk("post_rst_no_stale", 32'(n_out - out0), 32'd0);
    directed("post_rst", 16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
